// File: rtl/p_acc_ctrl_pkg.sv
// p_acc_ctrl_pkg: shared types for the partial-accumulate datapath.
//   dtype_t / dconf_t  : number format handed to p_acc (INT or FXP, sign, precision, fraction bits)
//   DEF_CONF           : signed 8-bit integer default
//   acc_ctrl_state_t   : p_acc_ctrl sequencer states
package p_acc_ctrl_pkg;

    typedef enum logic {INT, FXP} dtype_t;

    typedef struct packed {
        dtype_t     dtype;
        logic       sign;
        logic [7:0] prec;
        logic [7:0] frac;
    } dconf_t;

    localparam dconf_t DEF_CONF = '{dtype: INT, sign: 1'b1, prec: 8'd8, frac: 8'd0};

    typedef enum logic [1:0] {ACC_IDLE, ACC_LOAD, ACC_DONE} acc_ctrl_state_t;

endpackage

// File: rtl/p_acc_ctrl_p_acc.sv
// p_acc: combinational saturating adder of IN operands in CONF format.
//   in      : IN operands, PREC bits each
//   out     : sum, clamped to the CONF range
//   udf/ovf : exact sum fell below / rose above the representable range
//   rounded : set when precision was dropped
module p_acc
    import p_acc_ctrl_pkg::*;
#(
    parameter int     IN   = 5,
    parameter dconf_t CONF = DEF_CONF,
    localparam int    PREC = int'(CONF.prec)
) (
    input  logic [IN-1:0][PREC-1:0] in,
    output logic [PREC-1:0]         out,
    output logic                    udf,
    output logic                    ovf,
    output logic                    rounded
);

    // Wide enough that the exact sum of IN operands can never wrap.
    localparam int SW = PREC + $clog2(IN) + 1;

    localparam logic signed [SW-1:0] MAXV = CONF.sign ? SW'((64'sd1 <<< (PREC-1)) - 64'sd1)
                                                      : SW'((64'sd1 <<< PREC) - 64'sd1);
    localparam logic signed [SW-1:0] MINV = CONF.sign ? SW'(-(64'sd1 <<< (PREC-1)))
                                                      : SW'(64'sd0);

    logic signed [SW-1:0] sum;

    always_comb begin
        sum = '0;
        for (int i = 0; i < IN; i++) begin
            if (CONF.sign) sum = sum + SW'($signed(in[i]));
            else           sum = sum + $signed(SW'(in[i]));
        end
    end

    assign ovf = (sum > MAXV);
    assign udf = (sum < MINV);
    assign out = ovf ? MAXV[PREC-1:0] : (udf ? MINV[PREC-1:0] : sum[PREC-1:0]);

    // All operands share one format (same frac), so the sum is exact before clamping.
    assign rounded = 1'b0;

endmodule

// File: rtl/p_acc_ctrl.sv
// p_acc_ctrl: reduces a len-element stream to one sum through a single p_acc,
// IN-1 new elements per beat with the running sum fed back on lane 0.
//   clk, reset            : clock, synchronous active-high reset
//   start, len, busy      : command (sampled in IDLE), element count, busy in LOAD/DONE
//   in_valid/ready/data   : element beats, lane 0 earliest
//   out_valid/ready, out  : registered result handshake
//   udf, ovf, rounded     : sticky flags over the whole reduction
module p_acc_ctrl
    import p_acc_ctrl_pkg::*;
#(
    parameter int     IN    = 5,
    parameter dconf_t CONF  = DEF_CONF,
    parameter int     LEN_W = 8,
    localparam int    PREC  = int'(CONF.prec)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [LEN_W-1:0]          len,
    output logic                      busy,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IN-2:0][PREC-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PREC-1:0]           out,
    output logic                      udf,
    output logic                      ovf,
    output logic                      rounded
);

    acc_ctrl_state_t state_q, state_d;

    logic [PREC-1:0]          acc_q;
    logic [LEN_W-1:0]         rem_q;
    logic                     udf_q, ovf_q, rnd_q;

    logic [LEN_W-1:0]         n;
    logic [IN-1:0][PREC-1:0]  lanes;
    logic [PREC-1:0]          psum;
    logic                     p_udf, p_ovf, p_rnd;
    logic                     beat, clr;

    // Live lanes this beat: n = min(rem_q, IN-1).
    assign n = (rem_q < LEN_W'(IN-1)) ? rem_q : LEN_W'(IN-1);

    // Lane i of the beat is live iff i < rem_q; dead lanes are zeroed so
    // stale data past the end of the stream never reaches the sum.
    always_comb begin
        lanes    = '0;
        lanes[0] = acc_q;
        for (int i = 0; i < IN-1; i++)
            lanes[i+1] = (LEN_W'(i) < rem_q) ? in_data[i] : '0;
    end

    p_acc #(.IN(IN), .CONF(CONF)) u_p_acc (
        .in      (lanes),
        .out     (psum),
        .udf     (p_udf),
        .ovf     (p_ovf),
        .rounded (p_rnd)
    );

    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        beat      = 1'b0;
        clr       = 1'b0;
        case (state_q)
            ACC_IDLE: begin
                if (start) begin
                    clr     = 1'b1;
                    state_d = (len != '0) ? ACC_LOAD : ACC_DONE;
                end
            end
            ACC_LOAD: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid) begin
                    beat = 1'b1;
                    if (rem_q == n) state_d = ACC_DONE;
                end
            end
            ACC_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = ACC_IDLE;
            end
            default: state_d = ACC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ACC_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            rem_q <= '0;
            udf_q <= 1'b0;
            ovf_q <= 1'b0;
            rnd_q <= 1'b0;
        end else if (clr) begin
            acc_q <= '0;
            rem_q <= len;
            udf_q <= 1'b0;
            ovf_q <= 1'b0;
            rnd_q <= 1'b0;
        end else if (beat) begin
            acc_q <= psum;
            rem_q <= rem_q - n;
            udf_q <= udf_q | p_udf;
            ovf_q <= ovf_q | p_ovf;
            rnd_q <= rnd_q | p_rnd;
        end
    end

    assign out     = acc_q;
    assign udf     = udf_q;
    assign ovf     = ovf_q;
    assign rounded = rnd_q;

endmodule

// File: tb/tb_p_acc_ctrl.sv
// Self-checking bench for p_acc_ctrl (IN=5, signed INT8, 4 elements per beat).
module tb_p_acc_ctrl;
    import p_acc_ctrl_pkg::*;

    localparam int IN    = 5;
    localparam int LEN_W = 8;
    localparam int PREC  = 8;
    localparam int EPB   = IN - 1;
    localparam int NOCHK = -999;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic                      start = 1'b0;
    logic [LEN_W-1:0]          len = '0;
    logic                      busy;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic [EPB-1:0][PREC-1:0]  in_data = '0;
    logic                      out_valid;
    logic                      out_ready = 1'b0;
    logic [PREC-1:0]           out;
    logic                      udf, ovf, rounded;

    p_acc_ctrl #(.IN(IN), .CONF(DEF_CONF), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .udf(udf), .ovf(ovf), .rounded(rounded)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 taking elements, 2 result pending
    int m_phase = 0;
    int m_acc   = 0;
    int m_rem   = 0;
    bit m_udf   = 1'b0;
    bit m_ovf   = 1'b0;

    function automatic int sat8(input int v);
        if (v > 127)  return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic int nlive(input int r);
        return (r < EPB) ? r : EPB;
    endfunction

    function automatic int beat_sum(input int acc, input int r, input logic [EPB-1:0][PREC-1:0] d);
        int s;
        s = acc;
        for (int i = 0; i < nlive(r); i++) s += int'($signed(d[i]));
        return s;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_phase <= 0; m_acc <= 0; m_rem <= 0; m_udf <= 1'b0; m_ovf <= 1'b0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_acc <= 0; m_udf <= 1'b0; m_ovf <= 1'b0;
                    m_rem <= int'(len);
                    m_phase <= (len == 0) ? 2 : 1;
                end
                1: if (in_valid) begin
                    m_acc <= sat8(beat_sum(m_acc, m_rem, in_data));
                    if (beat_sum(m_acc, m_rem, in_data) > 127)  m_ovf <= 1'b1;
                    if (beat_sum(m_acc, m_rem, in_data) < -128) m_udf <= 1'b1;
                    m_rem <= m_rem - nlive(m_rem);
                    if (m_rem == nlive(m_rem)) m_phase <= 2;
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    // ---------------- cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",      int'(busy),              int'(m_phase != 0));
            chk("in_ready",  int'(in_ready),          int'(m_phase == 1));
            chk("out_valid", int'(out_valid),         int'(m_phase == 2));
            chk("out",       int'($signed(out)),      m_acc);
            chk("udf",       int'(udf),               int'(m_udf));
            chk("ovf",       int'(ovf),               int'(m_ovf));
            chk("rounded",   int'(rounded),           0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_red(input int L, input int el[32], input int gap_pct, input int hold,
                           input bit poke, input int exp_out, input int exp_u, input int exp_o);
        int idx, guard;
        bit acc;
        @(posedge clk); #2;
        start = 1'b1; len = LEN_W'(L);
        @(posedge clk); #2;
        start = 1'b0;
        idx = 0; guard = 0;
        while (idx < L && guard < 300) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            for (int i = 0; i < EPB; i++)
                in_data[i] = (idx + i < L) ? PREC'(el[idx+i]) : PREC'($urandom);
            acc = in_valid && in_ready;
            @(posedge clk); #2;
            if (acc) idx += EPB;
            guard++;
        end
        in_valid = 1'b0;
        in_data  = '0;
        if (guard >= 300) chk("beat_timeout", 0, 1);
        chk("done_latency", int'(out_valid), 1);
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(posedge clk); #2; guard++;
        end
        if (exp_out != NOCHK) begin
            chk("lit_out", int'($signed(out)), exp_out);
            chk("lit_udf", int'(udf), exp_u);
            chk("lit_ovf", int'(ovf), exp_o);
        end
        for (int h = 0; h < hold; h++) begin
            start = poke ? 1'b1 : 1'b0;
            len   = 8'd3;
            @(posedge clk); #2;
        end
        if (exp_out != NOCHK && hold > 0) begin
            chk("lit_hold_out", int'($signed(out)), exp_out);
            chk("lit_hold_valid", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        start     = poke;
        @(posedge clk); #2;
        out_ready = 1'b0;
        start     = 1'b0;
        if (exp_out != NOCHK) chk("lit_idle", int'(busy), 0);
    endtask

    initial begin
        int e[32];
        int L;

        @(posedge clk); #2;
        chk_en = 1'b1;
        @(posedge clk); #2;
        chk("rst_out",   int'(out), 0);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_valid", int'(out_valid), 0);
        reset = 1'b0;

        for (int i = 0; i < 32; i++) e[i] = i + 1;
        run_red(4,  e, 0,  0, 1'b0, 10, 0, 0);
        run_red(10, e, 0,  0, 1'b0, 55, 0, 0);
        run_red(10, e, 60, 0, 1'b0, 55, 0, 0);
        run_red(0,  e, 0,  0, 1'b0, 0,  0, 0);

        for (int i = 0; i < 32; i++) e[i] = 100;
        run_red(8, e, 0, 2, 1'b0, 127, 0, 1);
        for (int i = 0; i < 32; i++) e[i] = -100;
        run_red(8, e, 0, 2, 1'b0, -128, 1, 0);

        // result held under backpressure while start is pulsed
        for (int i = 0; i < 32; i++) e[i] = i + 1;
        run_red(4, e, 0, 5, 1'b1, 10, 0, 0);
        run_red(3, e, 0, 0, 1'b0, 6, 0, 0);

        // reset after the first beat of a len=10 run
        @(posedge clk); #2;
        start = 1'b1; len = 8'd10;
        @(posedge clk); #2;
        start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < EPB; i++) in_data[i] = PREC'(i + 1);
        @(posedge clk); #2;
        reset = 1'b1; start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0; start = 1'b0; out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
        chk("rst_mid_out",   int'(out), 0);
        chk("rst_mid_ready", int'(in_ready), 0);
        chk("rst_mid_busy",  int'(busy), 0);
        for (int i = 0; i < 32; i++) e[i] = 1;
        run_red(4, e, 0, 0, 1'b0, 4, 0, 0);

        // randomized reductions
        for (int t = 0; t < 40; t++) begin
            L = $urandom_range(20);
            for (int i = 0; i < 32; i++)
                e[i] = ($urandom_range(3) == 0) ? int'($signed(8'($urandom)))
                                                : int'($urandom_range(40)) - 20;
            run_red(L, e, $urandom_range(50), $urandom_range(3), 1'($urandom_range(1)),
                    NOCHK, 0, 0);
        end

        repeat (2) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
